// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake and data requests onto the single usb_tx command port.
// It also tracks the DATA0/DATA1 toggle and supervises each transfer with fill and start timeouts.
module usb_tx_scheduler #(
   parameter int START_TIMEOUT = 16,
   parameter int FILL_TIMEOUT  = 1024,
   parameter int CNT_W         = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic [1:0] hs_type,
   input  logic       data_req,
   input  logic [6:0] data_len,
   input  logic       toggle_clr,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   output logic [2:0] tx_packet,
   output logic       hs_grant,
   output logic       data_grant,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       data_toggle
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_FILL  = 3'd1;
   localparam logic [2:0] S_ISSUE      = 3'd2;
   localparam logic [2:0] S_WAIT_START = 3'd3;
   localparam logic [2:0] S_ACTIVE     = 3'd4;
   localparam logic [2:0] S_FINISH     = 3'd5;

   localparam logic [2:0] PKT_NONE  = 3'b000;
   localparam logic [2:0] PKT_DATA0 = 3'b001;
   localparam logic [2:0] PKT_DATA1 = 3'b010;

   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_FILL  = CNT_W'(FILL_TIMEOUT);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pkt_q, pkt_d;
   logic [6:0]       len_q, len_d;
   logic             is_data_q, is_data_d;
   logic             err_lat_q, err_lat_d;
   logic [2:0]       tx_packet_q, tx_packet_d;
   logic             hs_grant_q, hs_grant_d;
   logic             data_grant_q, data_grant_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             data_toggle_q, data_toggle_d;
   logic             toggle_flip;
   logic [CNT_W-1:0] cnt_inc;

   // Next-state, command and pulse computation for the transfer sequencer
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pkt_d        = pkt_q;
      len_d        = len_q;
      is_data_d    = is_data_q;
      err_lat_d    = err_lat_q;
      tx_packet_d  = PKT_NONE;
      hs_grant_d   = 1'b0;
      data_grant_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      toggle_flip  = 1'b0;
      // saturating increment so the timeout compare can never be skipped by wrap
      cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

      case (state_q)
         S_IDLE: begin
            cnt_d     = {CNT_W{1'b0}};
            err_lat_d = 1'b0;
            if (hs_req && (hs_type != 2'b00)) begin
               hs_grant_d = 1'b1;
               is_data_d  = 1'b0;
               pkt_d      = {1'b0, hs_type} + 3'd2;
               state_d    = S_ISSUE;
            end else if (data_req) begin
               data_grant_d = 1'b1;
               is_data_d    = 1'b1;
               len_d        = data_len;
               pkt_d        = data_toggle_q ? PKT_DATA1 : PKT_DATA0;
               state_d      = S_WAIT_FILL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_FILL: begin
            if (buffer_occupancy >= len_q) begin
               state_d = S_ISSUE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= CNT_FILL) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_FILL;
               end
            end
         end
         S_ISSUE: begin
            tx_packet_d = pkt_q;
            cnt_d       = {CNT_W{1'b0}};
            err_lat_d   = 1'b0;
            state_d     = S_WAIT_START;
         end
         S_WAIT_START: begin
            err_lat_d = err_lat_q | tx_error;
            if (tx_transfer_active) begin
               state_d = S_ACTIVE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc >= CNT_START) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_START;
               end
            end
         end
         S_ACTIVE: begin
            err_lat_d = err_lat_q | tx_error;
            // active dropping while in ACTIVE is the falling edge: result pulses during FINISH
            if (!tx_transfer_active) begin
               state_d = S_FINISH;
               if (err_lat_d) begin
                  err_d = 1'b1;
               end else begin
                  done_d      = 1'b1;
                  toggle_flip = is_data_q;
               end
            end else begin
               state_d = S_ACTIVE;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (toggle_clr) begin
         data_toggle_d = 1'b0;
      end else begin
         data_toggle_d = data_toggle_q ^ toggle_flip;
      end
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         pkt_q         <= PKT_NONE;
         len_q         <= 7'd0;
         is_data_q     <= 1'b0;
         err_lat_q     <= 1'b0;
         tx_packet_q   <= PKT_NONE;
         hs_grant_q    <= 1'b0;
         data_grant_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         data_toggle_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pkt_q         <= pkt_d;
         len_q         <= len_d;
         is_data_q     <= is_data_d;
         err_lat_q     <= err_lat_d;
         tx_packet_q   <= tx_packet_d;
         hs_grant_q    <= hs_grant_d;
         data_grant_q  <= data_grant_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         data_toggle_q <= data_toggle_d;
      end
   end

   assign tx_packet   = tx_packet_q;
   assign hs_grant    = hs_grant_q;
   assign data_grant  = data_grant_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign data_toggle = data_toggle_q;

endmodule
